// File: rtl/csr_trap_pkg.sv
// csr_trap_pkg: op/state encodings, machine CSR addresses and the known-address check for csr_trap_unit.
package csr_trap_pkg;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } trap_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TRAP,
        S_REDIR,
        S_RESP
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MCAUSE_ECALL_M = 11;

    function automatic logic csr_addr_known(input logic [11:0] addr);
        return addr inside {CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE};
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: new CSR value and write enable for CSRRW/CSRRS/CSRRC.
module csr_rmw_alu
    import csr_trap_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] old_val,
    input  logic [WIDTH-1:0] src,
    input  logic             src_zero,
    output logic [WIDTH-1:0] new_val,
    output logic             wen
);

    always_comb begin
        new_val = op == OP_CSRRS ? (old_val | src) :
                  op == OP_CSRRC ? (old_val & ~src) : src;
        // set/clear with x0/zimm=0 must not write, so read-only CSRs stay readable
        wen = op == OP_CSRRW || ((op == OP_CSRRS || op == OP_CSRRC) && !src_zero);
    end

endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: sequences CSR read-modify-write, ECALL trap entry and MRET redirect into the CSR file.
// Optional CSR_TRAP_ADDR_CHECK_EN rejects CSR ops outside mstatus/mtvec/mepc/mcause.
module csr_trap_unit
    import csr_trap_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [11:0]      req_csr,
    input  logic [WIDTH-1:0] req_src,
    input  logic             req_src_zero,
    input  logic [WIDTH-1:0] req_pc,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [11:0]      csr_addr,
    output logic             csr_wen,
    output logic [WIDTH-1:0] csr_wdata,
    output logic             csr_ecall,
    output logic [WIDTH-1:0] csr_pc,
    input  logic [WIDTH-1:0] csr_rdata,
    input  logic [WIDTH-1:0] csr_mtvec,
    input  logic [WIDTH-1:0] csr_mepc
);

    trap_state_e      state;
    logic [2:0]       op_q;
    logic [11:0]      csr_q;
    logic [WIDTH-1:0] src_q;
    logic             src_zero_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;
    logic             is_csr;
    logic             addr_ok;
    logic             alu_wen;

    always_comb begin
        is_csr = req_op == OP_CSRRW || req_op == OP_CSRRS || req_op == OP_CSRRC;
`ifdef CSR_TRAP_ADDR_CHECK_EN
        addr_ok = csr_addr_known(req_csr);
`else
        addr_ok = 1'b1;
`endif
    end

    csr_rmw_alu #(.WIDTH(WIDTH)) u_alu (
        .op       (op_q),
        .old_val  (rdata_q),
        .src      (src_q),
        .src_zero (src_zero_q),
        .new_val  (csr_wdata),
        .wen      (alu_wen)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            csr_q      <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            pc_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q       <= req_op;
                    csr_q      <= req_csr;
                    src_q      <= req_src;
                    src_zero_q <= req_src_zero;
                    pc_q       <= req_pc;
                    rdata_q    <= '0;
                    err_q      <= is_csr ? !addr_ok : req_op > OP_MRET;
                    state      <= is_csr ? (addr_ok ? S_READ : S_RESP) :
                                  req_op == OP_ECALL ? S_TRAP :
                                  req_op == OP_MRET  ? S_REDIR : S_RESP;
                end
                S_READ: begin
                    rdata_q <= csr_rdata;
                    state   <= S_WRITE;
                end
                S_WRITE: state <= S_RESP;
                S_TRAP:  state <= S_REDIR;
                S_REDIR: state <= S_RESP;
                S_RESP:  if (resp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready      = state == S_IDLE;
        resp_valid     = state == S_RESP;
        resp_rdata     = rdata_q;
        resp_err       = err_q;
        csr_addr       = csr_q;
        csr_wen        = state == S_WRITE && alu_wen;
        csr_ecall      = state == S_TRAP;
        csr_pc         = pc_q;
        redirect_valid = state == S_REDIR;
        // mtvec is sampled here, one cycle after trap entry updated the CSR file
        redirect_pc    = state != S_REDIR ? '0 : op_q == OP_ECALL ? csr_mtvec : csr_mepc;
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed vector table plus backpressure and mid-op reset sequences for csr_trap_unit.
module tb_csr_trap_unit;
    import csr_trap_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [11:0] req_csr = '0;
    logic [31:0] req_src = '0;
    logic        req_src_zero = 1'b0;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic        csr_ecall;
    logic [31:0] csr_pc;
    logic [31:0] csr_rdata = '0;
    logic [31:0] csr_mtvec = '0;
    logic [31:0] csr_mepc = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_trap_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
        .req_src(req_src), .req_src_zero(req_src_zero), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_ecall(csr_ecall),
        .csr_pc(csr_pc), .csr_rdata(csr_rdata), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc)
    );

    typedef struct {
        logic [2:0]  op;
        logic [11:0] csr;
        logic [31:0] src;
        logic        sz;
        logic [31:0] pc;
        logic [31:0] old;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        int          resp_cyc;
        int          wen_cyc;
        logic [31:0] wdata;
        int          ecall_cyc;
        int          redir_cyc;
        logic [31:0] redir_pc;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int wen_n = 0, wen_c = 0, ec_n = 0, ec_c = 0, rd_n = 0, rd_c = 0, resp_c = 0;
        logic [31:0] wd = '0, ecpc = '0, rdpc = '0;
        logic [11:0] wa = '0;
        @(negedge clk);
        csr_rdata = v.old; csr_mtvec = v.mtvec; csr_mepc = v.mepc;
        req_op = v.op; req_csr = v.csr; req_src = v.src; req_src_zero = v.sz; req_pc = v.pc;
        req_valid = 1'b1; resp_ready = 1'b0;
        check($sformatf("v%0d req_ready", idx), req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10 && resp_c == 0; c++) begin
            @(negedge clk);
            if (csr_wen) begin wen_n++; wen_c = c; wd = csr_wdata; wa = csr_addr; end
            if (csr_ecall) begin ec_n++; ec_c = c; ecpc = csr_pc; end
            if (redirect_valid) begin rd_n++; rd_c = c; rdpc = redirect_pc; end
            if (resp_valid) resp_c = c;
        end
        check($sformatf("v%0d resp_cycle", idx), resp_c, v.resp_cyc);
        check($sformatf("v%0d resp_rdata", idx), resp_rdata, v.rdata);
        check($sformatf("v%0d resp_err", idx), resp_err, v.err);
        check($sformatf("v%0d wen_count", idx), wen_n, v.wen_cyc != 0 ? 1 : 0);
        check($sformatf("v%0d wen_cycle", idx), wen_c, v.wen_cyc);
        check($sformatf("v%0d wdata", idx), wd, v.wdata);
        check($sformatf("v%0d waddr", idx), wa, v.wen_cyc != 0 ? v.csr : 12'h0);
        check($sformatf("v%0d ecall_count", idx), ec_n, v.ecall_cyc != 0 ? 1 : 0);
        check($sformatf("v%0d ecall_cycle", idx), ec_c, v.ecall_cyc);
        check($sformatf("v%0d ecall_pc", idx), ecpc, v.ecall_cyc != 0 ? v.pc : 32'h0);
        check($sformatf("v%0d redir_count", idx), rd_n, v.redir_cyc != 0 ? 1 : 0);
        check($sformatf("v%0d redir_cycle", idx), rd_c, v.redir_cyc);
        check($sformatf("v%0d redir_pc", idx), rdpc, v.redir_pc);
        handshake();
        @(negedge clk);
        check($sformatf("v%0d idle_after", idx), {req_ready, resp_valid}, 2'b10);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " resp_valid"}, resp_valid, 0);
        check({tag, " redirect_valid"}, redirect_valid, 0);
        check({tag, " csr_wen"}, csr_wen, 0);
        check({tag, " csr_ecall"}, csr_ecall, 0);
        check({tag, " data"}, resp_rdata | csr_wdata | csr_pc | redirect_pc, 0);
        check({tag, " addr_err"}, {csr_addr, resp_err}, 0);
    endtask

    initial begin
        //          op  csr     src           sz pc            old           mtvec         mepc          resp wen wdata        ecall redir rpc           rdata         err
        vecs[0]  = '{3'd0, 12'h305, 32'h8000_0100, 0, 32'h0,         32'h0,         32'h0,         32'h0,         3, 2, 32'h8000_0100, 0, 0, 32'h0,         32'h0,         0};
        vecs[1]  = '{3'd1, 12'h300, 32'h0000_1800, 0, 32'h0,         32'h8,         32'h0,         32'h0,         3, 2, 32'h0000_1808, 0, 0, 32'h0,         32'h8,         0};
        vecs[2]  = '{3'd2, 12'h300, 32'h0000_0008, 0, 32'h0,         32'h8,         32'h0,         32'h0,         3, 2, 32'h0,         0, 0, 32'h0,         32'h8,         0};
        vecs[3]  = '{3'd1, 12'h300, 32'h0,         1, 32'h0,         32'h8,         32'h0,         32'h0,         3, 0, 32'h0,         0, 0, 32'h0,         32'h8,         0};
        vecs[4]  = '{3'd2, 12'h342, 32'h0,         1, 32'h0,         32'hB,         32'h0,         32'h0,         3, 0, 32'h0,         0, 0, 32'h0,         32'hB,         0};
        vecs[5]  = '{3'd0, 12'h341, 32'h0,         1, 32'h0,         32'h1234,      32'h0,         32'h0,         3, 2, 32'h0,         0, 0, 32'h0,         32'h1234,      0};
        vecs[6]  = '{3'd3, 12'h0,   32'h0,         0, 32'h8000_0040, 32'hDEAD,      32'h8000_0100, 32'h0,         3, 0, 32'h0,         1, 2, 32'h8000_0100, 32'h0,         0};
        vecs[7]  = '{3'd4, 12'h0,   32'h0,         0, 32'h8000_0200, 32'hBEEF,      32'h8000_0100, 32'h8000_0044, 2, 0, 32'h0,         0, 1, 32'h8000_0044, 32'h0,         0};
        vecs[8]  = '{3'd5, 12'h300, 32'h5,         0, 32'h0,         32'h77,        32'h0,         32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         32'h0,         1};
        vecs[9]  = '{3'd7, 12'h305, 32'h0,         0, 32'h0,         32'h77,        32'h0,         32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         32'h0,         1};
        vecs[10] = '{3'd1, 12'h342, 32'h0000_FFFF, 0, 32'h0,         32'hFFFF_0000, 32'h0,         32'h0,         3, 2, 32'hFFFF_FFFF, 0, 0, 32'h0,         32'hFFFF_0000, 0};
`ifdef CSR_TRAP_ADDR_CHECK_EN
        vecs[11] = '{3'd0, 12'h7C0, 32'hA5A5_0000, 0, 32'h0,         32'h99,        32'h0,         32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         32'h0,         1};
`else
        vecs[11] = '{3'd0, 12'h7C0, 32'hA5A5_0000, 0, 32'h0,         32'h99,        32'h0,         32'h0,         3, 2, 32'hA5A5_0000, 0, 0, 32'h0,         32'h99,        0};
`endif

        #2 check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // backpressure: response held 5 cycles while a second request waits
        @(negedge clk);
        csr_rdata = 32'h8; req_op = 3'd1; req_csr = 12'h300; req_src = 32'h1800; req_src_zero = 1'b0;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_op = 3'd0; req_csr = 12'h305; req_src = 32'hCAFE_0000;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d hold", k), {resp_valid, req_ready}, 2'b10);
            check($sformatf("bp%0d rdata", k), resp_rdata, 32'h8);
            @(negedge clk);
        end
        handshake();
        @(negedge clk);
        check("bp idle gap", {req_ready, resp_valid}, 2'b10);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bp second accepted", req_ready, 0);
        @(negedge clk);
        check("bp second wen", csr_wen, 1);
        check("bp second wdata", csr_wdata, 32'hCAFE_0000);
        check("bp second addr", csr_addr, 12'h305);
        @(negedge clk);
        check("bp second resp", {resp_valid, resp_err}, 2'b10);
        check("bp second rdata", resp_rdata, 32'h8);
        handshake();

        // reset during WRITE
        @(negedge clk);
        csr_rdata = 32'h55; req_op = 3'd0; req_csr = 12'h305; req_src = 32'h1234_5678; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_write pre wen", csr_wen, 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_write");
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_write dropped", {resp_valid, csr_wen}, 2'b00);

        // reset during TRAP
        csr_mtvec = 32'h8000_0100; req_op = 3'd3; req_pc = 32'h8000_0040; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_trap pre ecall", csr_ecall, 1);
        check("rst_trap pre pc", csr_pc, 32'h8000_0040);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_trap");
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trap no redirect", {redirect_valid, resp_valid}, 2'b00);

        run_vec(vecs[1], 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Sequencing stage directly upstream of the machine-mode CSR register file. Accepts one CSR/system instruction at a time from execute (CSRRW/CSRRS/CSRRC, ECALL, MRET) over a valid/ready handshake. Drives the CSR file's address, write, ecall and pc inputs as a multi-cycle read-modify-write or trap sequence. Returns the old CSR value to writeback and issues a one-cycle PC redirect to fetch on ECALL/MRET.

## Interface
Parameters:
- WIDTH, 32, datapath width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at clk edge
- req_op  in  3  operation: 0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5–7 invalid
- req_csr  in  12  CSR address
- req_src  in  WIDTH  rs1 value, or zimm zero-extended
- req_src_zero  in  1  rs1 is x0 / zimm is 0
- req_pc  in  WIDTH  instruction PC
- resp_valid  out  1  result present; held until resp_ready
- resp_ready  in  1  writeback accepts result
- resp_rdata  out  WIDTH  old CSR value (0 for ECALL/MRET/error)
- resp_err  out  1  illegal request
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  WIDTH  redirect target
- csr_addr  out  12  CSR file address
- csr_wen  out  1  CSR file write enable
- csr_wdata  out  WIDTH  CSR file write data
- csr_ecall  out  1  CSR file trap-entry pulse
- csr_pc  out  WIDTH  PC for mepc capture
- csr_rdata  in  WIDTH  CSR file combinational read data
- csr_mtvec  in  WIDTH  current mtvec
- csr_mepc  in  WIDTH  current mepc

## Operation
- States: IDLE, READ, WRITE, TRAP, REDIR, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch op, csr, src, src_zero and pc.
  - CSR ops go to READ. ECALL goes to TRAP. MRET goes to REDIR.
  - Invalid op goes to RESP with err=1.
- READ:
  - csr_addr = latched csr.
  - Capture csr_rdata into rdata_q.
  - Compute new value: RW = src; RS = rdata_q | src; RC = rdata_q & ~src.
  - Go to WRITE.
- WRITE:
  - csr_addr held.
  - csr_wen=1 except RS/RC with src_zero=1, where csr_wen=0. RW always writes.
  - csr_wdata = new value.
  - Go to RESP.
- TRAP:
  - csr_ecall=1; csr_pc = latched pc.
  - Go to REDIR.
- REDIR:
  - redirect_valid=1.
  - redirect_pc = csr_mtvec for ECALL, csr_mepc for MRET.
  - Go to RESP.
- RESP:
  - resp_valid=1, resp_rdata and resp_err stable.
  - On resp_ready, go to IDLE.
  - No new request is accepted in the same cycle.
- Outside their states, csr_wen, csr_ecall and redirect_valid are 0. csr_addr and csr_wdata are don't-care but driven from registers (no latches).
- Exactly one request in flight at a time.

## Timing
- Reset (asynchronous):
  - State goes to IDLE; all latched fields and rdata_q are cleared to 0.
  - Outputs: req_ready=1, resp_valid=0, redirect_valid=0, csr_wen=0, csr_ecall=0; all data outputs 0.
  - An in-flight op is dropped with no CSR write.
  - Reset asserted during WRITE or TRAP suppresses that write or pulse immediately.
- CSR op: accept at edge 0; READ in cycle 1; WRITE in cycle 2; resp_valid from cycle 3.
- ECALL: TRAP in cycle 1, REDIR in cycle 2, resp_valid from cycle 3. redirect_pc samples csr_mtvec in cycle 2, after mepc/mcause are updated.
- MRET: REDIR in cycle 1, resp_valid from cycle 2.
- Invalid op: resp_valid from cycle 1, no CSR activity.
- Minimum spacing between accepts: resp handshake cycle plus one IDLE cycle.
- resp_ready held low: RESP persists indefinitely and outputs stay stable.
- redirect_valid is exactly one cycle per ECALL/MRET, independent of resp_ready.

## Configuration
- CSR_TRAP_ADDR_CHECK_EN defined:
  - CSR ops whose req_csr is not 0x300, 0x305, 0x341 or 0x342 skip READ/WRITE.
  - They go straight to RESP with resp_err=1 and resp_rdata=0; no csr_wen.
- Undefined: the address is passed through unchecked. The CSR file's own decode applies.

## Structure
- Package csr_trap_pkg:
  - trap_op_e (3-bit op encoding) and trap_state_e.
  - CSR address constants CSR_MSTATUS=12'h300, CSR_MTVEC=12'h305, CSR_MEPC=12'h341, CSR_MCAUSE=12'h342.
  - MCAUSE_ECALL_M=11.
- One sub-module: csr_rmw_alu, combinational. Inputs op, old value, src, src_zero; outputs new value and write-enable.

## Test plan
- CSRRW: mtvec preloaded 0x0 (rdata 0), src=0x8000_0100 -> WRITE-cycle csr_wen=1, wdata 0x8000_0100, resp_rdata 0x0 at cycle 3.
- CSRRS/CSRRC: mstatus old 0x0000_0008.
  - CSRRS src=0x1800 -> wdata 0x1808, rdata 0x8.
  - CSRRC src=0x8 -> wdata 0x0.
  - CSRRS with src_zero=1 -> csr_wen never 1, rdata 0x8.
- ECALL: pc=0x8000_0040, mtvec=0x8000_0100 -> csr_ecall pulse cycle 1 with csr_pc 0x8000_0040; redirect_valid cycle 2 with pc 0x8000_0100; resp_rdata 0.
- MRET: mepc=0x8000_0040 -> redirect_valid cycle 1 with 0x8000_0044 only if mepc was written to that value. Check target equals csr_mepc exactly and no csr_wen or csr_ecall.
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid and rdata stable, req_ready=0, second req_valid not accepted until one cycle after the handshake.
- Reset mid-op: assert rst during WRITE -> csr_wen drops same cycle, all outputs at reset values. With CSR_TRAP_ADDR_CHECK_EN, req_csr=0x7C0 -> resp_err=1 at cycle 1, no csr_wen.
